// File: rtl/piso_frame_serializer.sv
// Parallel-in/serial-out framer: captures one word in IDLE and emits it one bit per cycle.
// Optional even-parity bit after the data bits when SERIALIZER_PARITY_EN is defined.
module piso_frame_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MSB_FIRST  = 1,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frame_count
);
    localparam int unsigned CNT_W    = $clog2(WIDTH + 1);
    localparam int unsigned GAP_W    = 4;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam bit          MSB      = (MSB_FIRST != 0);

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2, PARITY = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;
`endif

    localparam state_t POST_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

    state_t             state, state_n;
    logic [WIDTH-1:0]   shreg, shreg_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [GAP_W-1:0]   gap_cnt, gap_n;
    logic               ready_n, bit_n, valid_n, busy_n, done_n;
    logic [15:0]        count_n;
`ifdef SERIALIZER_PARITY_EN
    logic               par_q, par_n;
`endif

    // Next bit to send from a word, honouring the configured bit order
    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB ? w[WIDTH-1] : w[0];
    endfunction

    // Word with the head bit consumed
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB ? (w << 1) : (w >> 1);
    endfunction

    // Outputs are registered, so each transition also computes what the next cycle shows
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        gap_n   = gap_cnt;
        bit_n   = 1'b0;
        valid_n = 1'b0;
        done_n  = 1'b0;
        count_n = frame_count + 16'(frame_done);
`ifdef SERIALIZER_PARITY_EN
        par_n   = par_q;
`endif
        case (state)
            IDLE: begin
                if (data_valid && data_ready) begin
                    state_n = SHIFT;
                    valid_n = 1'b1;
                    bit_n   = head(data_in);
                    shreg_n = advance(data_in);
                    cnt_n   = CNT_W'(1);
`ifdef SERIALIZER_PARITY_EN
                    par_n   = ^data_in;
`endif
                end
            end
            SHIFT: begin
                if (cnt < CNT_W'(WIDTH)) begin
                    valid_n = 1'b1;
                    bit_n   = head(shreg);
                    shreg_n = advance(shreg);
                    cnt_n   = cnt + CNT_W'(1);
`ifndef SERIALIZER_PARITY_EN
                    done_n  = (cnt == CNT_W'(WIDTH - 1));
`endif
                end else begin
`ifdef SERIALIZER_PARITY_EN
                    state_n = PARITY;
                    valid_n = 1'b1;
                    bit_n   = par_q;
                    done_n  = 1'b1;
`else
                    state_n = POST_FRAME;
                    gap_n   = '0;
`endif
                end
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
                state_n = POST_FRAME;
                gap_n   = '0;
            end
`endif
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_LAST)) begin
                    state_n = IDLE;
                end else begin
                    gap_n = gap_cnt + GAP_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == IDLE);
        busy_n  = (state_n != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            gap_cnt     <= '0;
            data_ready  <= 1'b0;
            bit_out     <= 1'b0;
            bit_valid   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
`ifdef SERIALIZER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            cnt         <= cnt_n;
            gap_cnt     <= gap_n;
            data_ready  <= ready_n;
            bit_out     <= bit_n;
            bit_valid   <= valid_n;
            busy        <= busy_n;
            frame_done  <= done_n;
            frame_count <= count_n;
`ifdef SERIALIZER_PARITY_EN
            par_q       <= par_n;
`endif
        end
    end
endmodule

// File: doc/piso_frame_serializer.md
PISO_FRAME_SERIALIZER -- requirements
Module: piso_frame_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1; 1 means bit WIDTH-1 is sent first, 0 means bit 0 is sent first.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 0, giving the idle cycles inserted after each frame (legal range 0..15).
REQ-004 clk  input  1  clock; all logic is rising-edge triggered.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data_in  input  WIDTH  parallel word to serialize.
REQ-007 data_valid  input  1  upstream word present on data_in.
REQ-008 data_ready  output  1  block can accept a word this cycle.
REQ-009 bit_out  output  1  serial data bit; drives the serial input of the downstream shift register.
REQ-010 bit_valid  output  1  bit_out is valid this cycle; drives the shift enable of the downstream shift register.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 frame_done  output  1  one-cycle pulse on the final bit of a frame.
REQ-013 frame_count  output  16  number of completed frames.

Function
REQ-014 The FSM SHALL have the states IDLE, SHIFT, PARITY (present only with the macro in REQ-029) and GAP.
REQ-015 In IDLE, data_ready SHALL be 1; in all other states it SHALL be 0.
REQ-016 A word SHALL be accepted when data_valid and data_ready are both 1 at a rising edge.
- data_in is captured into an internal register.
- The bit counter is cleared.
- The FSM moves to SHIFT.
REQ-017 data_valid while data_ready is 0 SHALL be ignored, with no capture and no stall; upstream holds its word until accepted.
REQ-018 In SHIFT, bit_valid SHALL be 1 for exactly WIDTH consecutive cycles, presenting one captured bit per cycle in the order set by MSB_FIRST.
REQ-019 The first bit_valid SHALL occur in the cycle after the accepting edge, giving a latency of 1 cycle.
REQ-020 When bit_valid is 0, bit_out SHALL be 0.
REQ-021 After the last data bit, the FSM SHALL go to PARITY if the macro is defined; otherwise to GAP if GAP_CYCLES > 0; otherwise to IDLE.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles with bit_valid 0, then return to IDLE.
REQ-023 frame_done SHALL pulse high for one cycle, coincident with the final bit_valid cycle of the frame (the last data bit, or the parity bit).
REQ-024 frame_count SHALL increment by 1 on each frame_done and wrap from 16'hFFFF to 0.
REQ-025 The minimum frame period SHALL be WIDTH + 1 + GAP_CYCLES cycles (+1 with parity), because acceptance happens only in IDLE.
REQ-026 Changes on data_in after acceptance SHALL NOT affect the frame in progress.

Reset
REQ-027 On reset assertion, regardless of clock, the outputs SHALL immediately take these values:
- bit_out = 0, bit_valid = 0, busy = 0, frame_done = 0, frame_count = 0, data_ready = 0.
- The FSM goes to IDLE; the capture register and bit counter are cleared.
REQ-028 Reset mid-frame SHALL abort the frame with no frame_done and no count increment.
- data_ready SHALL be 1 on the first cycle after reset deassertion.

Configuration
REQ-029 With macro SERIALIZER_PARITY_EN defined, the PARITY state SHALL emit one extra bit_valid cycle carrying the even parity (XOR of all WIDTH captured bits) after the data bits.
- In this case, frame_done accompanies the parity bit.
REQ-030 Without SERIALIZER_PARITY_EN, there SHALL be no PARITY state and no parity logic; each frame is exactly WIDTH bit_valid cycles.

Verification
REQ-031 WIDTH=8, MSB_FIRST=1, no macro; accept 8'hA5 at edge T -> bit_valid high T+1..T+8, bit_out 1,0,1,0,0,1,0,1; frame_done at T+8; frame_count=1; data_ready=1 at T+9.
REQ-032 MSB_FIRST=0, accept 8'h01 -> bit_out 1,0,0,0,0,0,0,0.
REQ-033 SERIALIZER_PARITY_EN, accept 8'h07 -> 8 data bits, then a 9th bit_valid cycle with bit_out=1; frame_done on the 9th cycle.
REQ-034 GAP_CYCLES=3, data_valid held high with two words -> 3 cycles of bit_valid=0 plus 1 IDLE cycle between frames; second frame starts 12 cycles after the first.
REQ-035 Assert reset after the 4th bit of 8'hFF -> bit_valid=0 immediately; no frame_done; frame_count=0; data_ready=1 on the first cycle after reset deassertion; next word serializes fully.
REQ-036 Force frame_count to 16'hFFFF and complete one frame -> frame_count=0.
